// File: rtl/wfg_stim_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : wfg_stim_mem_seq
// Description : Stimulus-memory sequencer. Reads samples from a single-port
//               SRAM in wrap, bounce, infinite or N-pass modes and streams
//               them on an AXI-Stream master through a small prefetch FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module wfg_stim_mem_seq #(
  parameter int AW     = 10,
  parameter int DW     = 32,
  parameter int FDEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ctrl_en_q_i,
  input  logic [1:0]    ctrl_mode_q_i,
  input  logic [AW-1:0] start_val_q_i,
  input  logic [AW-1:0] end_val_q_i,
  input  logic [7:0]    inc_val_q_i,
  input  logic [7:0]    rep_val_q_i,
  input  logic          wfg_axis_tready_i,
  output logic          wfg_axis_tvalid_o,
  output logic [DW-1:0] wfg_axis_tdata_o,
  output logic          csb_o,
  output logic [AW-1:0] addr_o,
  input  logic [DW-1:0] dout_i,
  output logic          busy_o,
  output logic          done_o
);

  localparam int PW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
  localparam int CW = $clog2(FDEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] start_q, start_d, end_q, end_d, p_q, p_d, addr_q, addr_d;
  logic [7:0]    inc_q, inc_d, rep_q, rep_d, pass_q, pass_d;
  logic [1:0]    mode_q, mode_d;
  logic          dir_q, dir_d;          // 1 = walking down (bounce)
  logic          inflight_q, inflight_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [DW-1:0] mem_q [FDEPTH];
  logic [DW-1:0] mem_d [FDEPTH];

  logic          issue, pop, push, credit;
  logic [AW-1:0] p_adv;
  logic          dir_adv, pass_adv;
  logic [AW:0]   p_ext, e_ext, inc_ext, p_up, p_dn, dn_lim;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Next pointer/direction for the current read; one extra bit avoids overflow
  always_comb begin
    p_ext    = {1'b0, p_q};
    e_ext    = {1'b0, end_q};
    inc_ext  = (AW+1)'(inc_q);
    p_up     = p_ext + inc_ext;
    p_dn     = p_ext - inc_ext;
    dn_lim   = {1'b0, start_q} + inc_ext;
    p_adv    = p_q;
    dir_adv  = dir_q;
    pass_adv = 1'b0;
    if (start_q == end_q) begin
      pass_adv = 1'b1;
    end else if (!mode_q[0]) begin
      if (p_up > e_ext) begin
        p_adv    = start_q;
        pass_adv = 1'b1;
      end else begin
        p_adv = p_up[AW-1:0];
      end
    end else if (!dir_q) begin
      if (p_up <= e_ext) begin
        p_adv = p_up[AW-1:0];
      end else begin
        dir_adv = 1'b1;
        p_adv   = (p_ext >= dn_lim) ? p_dn[AW-1:0] : start_q;
      end
    end else begin
      if (p_ext >= dn_lim) begin
        p_adv = p_dn[AW-1:0];
      end else begin
        dir_adv  = 1'b0;
        p_adv    = (p_up <= e_ext) ? p_up[AW-1:0] : end_q;
        pass_adv = 1'b1;
      end
    end
  end

  // FSM next state, read issue, config latch and FIFO bookkeeping
  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    end_d      = end_q;
    inc_d      = inc_q;
    rep_d      = rep_q;
    mode_d     = mode_q;
    p_d        = p_q;
    dir_d      = dir_q;
    pass_d     = pass_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;
    issue      = 1'b0;
    pop        = (cnt_q != '0) && wfg_axis_tready_i;
    push       = inflight_q;
    // Count what will be held or arriving after this edge, net of the pop
    credit     = (int'(cnt_q) + int'(inflight_q)) < (FDEPTH + int'(pop));

    unique case (state_q)
      S_IDLE: begin
        if (ctrl_en_q_i) begin
          state_d = S_RUN;
          start_d = start_val_q_i;
          end_d   = (start_val_q_i > end_val_q_i) ? start_val_q_i : end_val_q_i;
          inc_d   = (inc_val_q_i == 8'd0) ? 8'd1 : inc_val_q_i;
          rep_d   = rep_val_q_i;
          mode_d  = ctrl_mode_q_i;
          p_d     = start_val_q_i;
          dir_d   = 1'b0;
          pass_d  = 8'd0;
        end
      end
      S_RUN: begin
        if (credit) begin
          issue  = 1'b1;
          addr_d = p_q;
          p_d    = p_adv;
          dir_d  = dir_adv;
          if (pass_adv) begin
            if (mode_q[1] && (pass_q == rep_q)) state_d = S_DRAIN;
            else                                pass_d  = pass_q + 8'd1;
          end
        end
      end
      default: ;
    endcase

    inflight_d = issue;

    if (push) begin
      mem_d[wr_q] = dout_i;
      wr_d        = ptr_inc(wr_q);
    end
    if (pop) rd_d = ptr_inc(rd_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Last word leaves the FIFO on this edge with nothing behind it
    if ((state_q == S_DRAIN) && (cnt_d == '0) && !inflight_q) state_d = S_DONE;

    // Abort: flush FIFO and drop any read still returning
    if (!ctrl_en_q_i) begin
      state_d    = S_IDLE;
      inflight_d = 1'b0;
      cnt_d      = '0;
      rd_d       = '0;
      wr_d       = '0;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      start_q    <= '0;
      end_q      <= '0;
      inc_q      <= 8'd1;
      rep_q      <= '0;
      mode_q     <= '0;
      p_q        <= '0;
      dir_q      <= 1'b0;
      pass_q     <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      for (int i = 0; i < FDEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      end_q      <= end_d;
      inc_q      <= inc_d;
      rep_q      <= rep_d;
      mode_q     <= mode_d;
      p_q        <= p_d;
      dir_q      <= dir_d;
      pass_q     <= pass_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      mem_q      <= mem_d;
    end
  end

  // Output decode; tdata forced to zero while the FIFO is empty
  always_comb begin
    wfg_axis_tvalid_o = (cnt_q != '0);
    wfg_axis_tdata_o  = wfg_axis_tvalid_o ? mem_q[rd_q] : '0;
    csb_o             = !issue;
    addr_o            = issue ? p_q : addr_q;
    busy_o            = (state_q == S_RUN) || (state_q == S_DRAIN);
    done_o            = (state_q == S_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_wfg_stim_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_wfg_stim_mem_seq
// Description : Directed self-checking bench for wfg_stim_mem_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wfg_stim_mem_seq;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int FDEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] sv = '0;
  logic [AW-1:0] ev = '0;
  logic [7:0]    iv = 8'd1;
  logic [7:0]    rv = 8'd0;
  logic          tready = 1'b0;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          csb;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout = '0;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  wfg_stim_mem_seq #(.AW(AW), .DW(DW), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_en_q_i(en), .ctrl_mode_q_i(mode),
    .start_val_q_i(sv), .end_val_q_i(ev), .inc_val_q_i(iv), .rep_val_q_i(rv),
    .wfg_axis_tready_i(tready), .wfg_axis_tvalid_o(tvalid),
    .wfg_axis_tdata_o(tdata), .csb_o(csb), .addr_o(addr), .dout_i(dout),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // SRAM model: mem[i] = 0x1000 + i, one-cycle read latency
  always @(posedge clk) if (!csb) dout <= 32'h1000 + 32'(addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic stop_run;
    en = 1'b0;
    tick();
    tick();
  endtask

  // Configure and enable; returns just after the third edge (first word visible)
  task automatic go(input logic [1:0] m, input int s, input int e, input int inc, input int rep);
    mode = m; sv = s[AW-1:0]; ev = e[AW-1:0]; iv = inc[7:0]; rv = rep[7:0];
    en = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (tvalid !== 1'b0 || tdata !== '0 || csb !== 1'b1 || addr !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got tvalid=%b tdata=%h csb=%b addr=%0d busy=%b done=%b, expected 0,0,1,0,0,0",
               tvalid, tdata, csb, addr, busy, done);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_loop;
    mode = 2'd0; sv = 10'd2; ev = 10'd5; iv = 8'd1; rv = 8'd0; tready = 1'b1;
    en = 1'b1;
    tick();  // after E0
    checks++;
    if (csb !== 1'b0 || addr !== 10'd2 || busy !== 1'b1 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL loop_e0: got csb=%b addr=%0d busy=%b tvalid=%b, expected 0,2,1,0", csb, addr, busy, tvalid);
    end
    tick();  // after E1
    checks++;
    if (tvalid !== 1'b0) begin
      errors++;
      $display("FAIL loop_e1_tvalid: got %b expected 0", tvalid);
    end
    tick();  // after E2
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'h1002 + 32'(k % 4)) begin
        errors++;
        $display("FAIL loop_word[%0d]: got tvalid=%b tdata=%h expected 1 %h", k, tvalid, tdata, 32'h1002 + 32'(k % 4));
      end
      tick();
    end
    stop_run();
  endtask

  task automatic test_one_shot;
    tready = 1'b1;
    go(2'd2, 0, 6, 3, 1);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'h1000 + 32'(3 * (k % 3))) begin
        errors++;
        $display("FAIL oneshot_word[%0d]: got tvalid=%b tdata=%h expected 1 %h", k, tvalid, tdata, 32'h1000 + 32'(3 * (k % 3)));
      end
      tick();
    end
    checks++;
    if (tvalid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_done: got tvalid=%b done=%b busy=%b expected 0 1 0", tvalid, done, busy);
    end
    tick(); tick(); tick();
    checks++;
    if (done !== 1'b1 || csb !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_hold: got done=%b csb=%b expected 1 1", done, csb);
    end
    en = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_release: got done=%b expected 0", done);
    end
    tick();
  endtask

  task automatic test_bounce;
    int bnc [10] = '{0, 2, 4, 2, 0, 2, 4, 2, 0, 2};
    tready = 1'b1;
    go(2'd1, 0, 4, 2, 0);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'h1000 + 32'(bnc[k])) begin
        errors++;
        $display("FAIL bounce_word[%0d]: got tvalid=%b tdata=%h expected 1 %h", k, tvalid, tdata, 32'h1000 + 32'(bnc[k]));
      end
      tick();
    end
    stop_run();
  endtask

  task automatic test_overflow_inc0;
    tready = 1'b1;
    go(2'd0, 1020, 1023, 3, 0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'h1000 + 32'(1020 + 3 * (k % 2))) begin
        errors++;
        $display("FAIL ovf_word[%0d]: got tvalid=%b tdata=%h expected 1 %h", k, tvalid, tdata, 32'h1000 + 32'(1020 + 3 * (k % 2)));
      end
      if (!csb) begin
        checks++;
        if (addr < 10'd1020) begin
          errors++;
          $display("FAIL ovf_addr[%0d]: got %0d expected 1020..1023", k, addr);
        end
      end
      tick();
    end
    stop_run();
    go(2'd0, 0, 3, 0, 0);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'h1000 + 32'(k % 4)) begin
        errors++;
        $display("FAIL inc0_word[%0d]: got tvalid=%b tdata=%h expected 1 %h", k, tvalid, tdata, 32'h1000 + 32'(k % 4));
      end
      tick();
    end
    stop_run();
  endtask

  task automatic test_backpressure;
    logic          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int            cnt_m = 0, infl_m = 0, exp_idx = 0, words = 0;
    logic          prev_hs = 1'b0, prev_issue = 1'b0, held_v = 1'b0;
    logic          hs, issue, credit_m;
    logic [DW-1:0] held = '0;
    mode = 2'd0; sv = 10'd0; ev = 10'd9; iv = 8'd1; rv = 8'd0;
    tready = 1'b0;
    en = 1'b1;
    for (int cyc = 0; cyc < 48; cyc++) begin
      @(posedge clk);
      cnt_m  = cnt_m + infl_m - int'(prev_hs);
      infl_m = int'(prev_issue);
      #1 tready = pat[cyc % 4];
      #1;
      hs       = tvalid && tready;
      issue    = !csb;
      credit_m = (cnt_m + infl_m - int'(hs)) < FDEPTH;
      checks++;
      if (tvalid !== (cnt_m != 0)) begin
        errors++;
        $display("FAIL bp_tvalid[%0d]: got %b expected %b", cyc, tvalid, (cnt_m != 0));
      end
      checks++;
      if (issue !== credit_m) begin
        errors++;
        $display("FAIL bp_issue[%0d]: got csb=%b expected csb=%b", cyc, csb, !credit_m);
      end
      if (held_v) begin
        checks++;
        if (tvalid !== 1'b1 || tdata !== held) begin
          errors++;
          $display("FAIL bp_stable[%0d]: got tvalid=%b tdata=%h expected 1 %h", cyc, tvalid, tdata, held);
        end
      end
      if (hs) begin
        checks++;
        if (tdata !== 32'h1000 + 32'(exp_idx)) begin
          errors++;
          $display("FAIL bp_word[%0d]: got %h expected %h", cyc, tdata, 32'h1000 + 32'(exp_idx));
        end
        exp_idx = (exp_idx + 1) % 10;
        words++;
      end
      held_v     = tvalid && !tready;
      held       = tdata;
      prev_hs    = hs;
      prev_issue = issue;
    end
    checks++;
    if (words < 20) begin
      errors++;
      $display("FAIL bp_words: got %0d expected at least 20", words);
    end
    #3;
    stop_run();
  endtask

  task automatic test_abort;
    tready = 1'b0;
    go(2'd0, 3, 8, 1, 0);
    tick(); tick(); tick();
    checks++;
    if (tvalid !== 1'b1 || tdata !== 32'h1003 || csb !== 1'b1) begin
      errors++;
      $display("FAIL abort_full: got tvalid=%b tdata=%h csb=%b expected 1 1003 1", tvalid, tdata, csb);
    end
    en = 1'b0;
    tick();
    checks++;
    if (tvalid !== 1'b0 || csb !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_drop: got tvalid=%b csb=%b busy=%b done=%b expected 0 1 0 0", tvalid, csb, busy, done);
    end
    tick(); tick();
    tready = 1'b1;
    en = 1'b1;
    tick();
    checks++;
    if (csb !== 1'b0 || addr !== 10'd3 || tvalid !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart_e0: got csb=%b addr=%0d tvalid=%b expected 0 3 0", csb, addr, tvalid);
    end
    tick();
    checks++;
    if (tvalid !== 1'b0) begin
      errors++;
      $display("FAIL abort_restart_e1: got tvalid=%b expected 0", tvalid);
    end
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (tvalid !== 1'b1 || tdata !== 32'h1003 + 32'(k)) begin
        errors++;
        $display("FAIL abort_word[%0d]: got tvalid=%b tdata=%h expected 1 %h", k, tvalid, tdata, 32'h1003 + 32'(k));
      end
      tick();
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (tvalid !== 1'b0 || tdata !== '0 || csb !== 1'b1 || addr !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: got tvalid=%b tdata=%h csb=%b addr=%0d busy=%b done=%b, expected 0,0,1,0,0,0",
               tvalid, tdata, csb, addr, busy, done);
    end
    en = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_loop();
    test_one_shot();
    test_bounce();
    test_overflow_inc0();
    test_backpressure();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wfg_stim_mem_seq.md
# wfg_stim_mem_seq

Parametrised stimulus-memory sequencer for the waveform generator: reads samples from an external single-port SRAM and streams them on an AXI-Stream master port. It supersedes the fixed 10-bit/32-bit stimulus reader with:
- configurable address and data widths
- loop, one-shot (N passes) and bounce (ping-pong) addressing modes
- a prefetch FIFO that sustains one word per cycle under continuous `tready`
- a done status output

It sits between the wishbone register block and a downstream AXI-Stream consumer such as an SPI or PWM driver.

## Interface

Parameters
- `AW`, 10: SRAM address width.
- `DW`, 32: sample/data width.
- `FDEPTH`, 2: prefetch FIFO depth; must be ≥2.

Ports
- `clk` input 1: clock; all logic on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `ctrl_en_q_i` input 1: enable. Rising level starts a run; low aborts.
- `ctrl_mode_q_i` input 2: bit0 selects bounce (1) or wrap (0); bit1 selects finite passes (1) or infinite (0).
- `start_val_q_i` input AW: first address.
- `end_val_q_i` input AW: last address, inclusive.
- `inc_val_q_i` input 8: address step; 0 is treated as 1.
- `rep_val_q_i` input 8: number of passes minus 1; used only when `ctrl_mode_q_i[1]` is 1.
- `wfg_axis_tready_i` input 1: downstream ready.
- `wfg_axis_tvalid_o` output 1: data valid.
- `wfg_axis_tdata_o` output DW: FIFO head word.
- `csb_o` output 1: SRAM chip select, active-low. Reads only.
- `addr_o` output AW: SRAM address.
- `dout_i` input DW: SRAM read data, valid the cycle after `csb_o` is low.
- `busy_o` output 1: state is RUN or DRAIN.
- `done_o` output 1: state is DONE.

## Operation

Registers `start`, `end`, `inc`, `mode` and `rep` are latched on IDLE→RUN. Changes during a run are ignored until the next run.
- If `start` > `end`, effective `end` = `start`.

**FSM**
- **IDLE**: on `ctrl_en_q_i`=1, go to RUN. Set pointer p=start, direction=up, pass count=0.
- **RUN**: issue reads. When the last read of the final pass is issued (finite mode only), go to DRAIN.
- **DRAIN**: no reads issued. When the FIFO is empty and no read is in flight, go to DONE.
- **DONE**: hold until `ctrl_en_q_i`=0, then go to IDLE.
- **Abort**: `ctrl_en_q_i`=0 in any state goes to IDLE next edge. The FIFO is flushed and in-flight data is discarded. Dropping `tvalid` without a handshake here is intended.

**Read issue** (RUN only)
- Credit condition: FIFO count + in-flight − (pop this cycle) < FDEPTH.
- When credit exists, drive `csb_o`=0 and `addr_o`=p, then advance p.
- Otherwise `csb_o`=1 and `addr_o` holds its last value.
- The returned `dout_i` is pushed into the FIFO on the following edge.

**Pointer advance** (arithmetic in AW+1 bits, inc zero-extended)
- Wrap mode: if p+inc > end, then p=start and one pass completes; else p=p+inc.
- Bounce, up: if p+inc ≤ end, then p+inc. Otherwise set dir=down and p = max(p−inc, start).
- Bounce, down: if p ≥ start+inc, then p−inc. Otherwise set dir=up, p = min(p+inc, end), and one pass completes.
- start == end: p stays at start. Each issue is one pass.

**Finite mode**
- Run completes after rep+1 passes.
- The read that completes the final pass is the last read issued.

**AXI-Stream**
- `tvalid` = FIFO not empty. `tdata` = FIFO head.
- Pop occurs on `tvalid && tready`.
- `tdata` is stable while `tvalid && !tready`.

## Timing

- Reset values: `wfg_axis_tvalid_o`=0, `wfg_axis_tdata_o`=0, `csb_o`=1, `addr_o`=0, `busy_o`=0, `done_o`=0. FSM=IDLE, FIFO empty.
- Start-up latency: en sampled high at edge E0 gives RUN after E0. First `csb_o`=0 in the cycle after E0. Data is pushed at E2, and `tvalid`=1 after E2.
- Throughput: with `tready` held at 1, one word per cycle in steady state with no bubbles, including at wrap and bounce turnarounds.
- Completion: `done_o` rises the cycle after the last word handshake.
- Abort: `ctrl_en_q_i` low sampled at edge En gives `tvalid`=0, `csb_o`=1, `busy_o`=0 and `done_o`=0 after En.
- Re-enable: a later re-enable restarts from `start`.
- Reset mid-run: identical to the reset values above.

## Test plan

SRAM model: mem[i] = 0x1000+i, 1-cycle read latency.

1. **Loop**
   - Stimulus: mode=0, start=2, end=5, inc=1, `tready`=1.
   - Required: `tdata` sequence 0x1002,0x1003,0x1004,0x1005,0x1002,… with no gaps after the first word. First `tvalid` 3 edges after en.
2. **One-shot**
   - Stimulus: mode=2, start=0, end=6, inc=3, rep=1.
   - Required: 0x1000,0x1003,0x1006,0x1000,0x1003,0x1006, then `tvalid`=0 and `done_o`=1. `done_o` stays high until en=0.
3. **Bounce**
   - Stimulus: mode=1, start=0, end=4, inc=2.
   - Required: 0x1000,0x1002,0x1004,0x1002,0x1000,0x1002,0x1004,…
4. **Overflow wrap and inc=0**
   - Stimulus A: start=1020, end=1023, inc=3. Required: 1020,1023,1020,… with no out-of-range address.
   - Stimulus B: inc=0. Required: increments by 1.
5. **Backpressure**
   - Stimulus: `tready` random (pattern 1,0,0,1,…).
   - Required: no lost or duplicated words. `tdata` stable while stalled. `csb_o`=1 whenever credits are exhausted. In-flight count never exceeds FDEPTH.
6. **Abort**
   - Stimulus: en dropped mid-run with FIFO full, then raised after 3 cycles.
   - Required: `tvalid`=0 next cycle. The stream restarts at `start` with the standard latency. Applying `rst_n`=0 mid-run gives all outputs at their reset values after the edge.
